pipe_fetch_unit: RTL and testbench

- Instruction-fetch front end of the 5-stage pipelined CPU. Directly upstream of the ID stage; replaces the bare PC + Adder + IF_ID register path.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Buffers returned instructions in a small in-order queue and presents them to ID with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding in-flight wrong-path responses.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_fetch_unit_if.sv | 13 +
 rtl/fetch_queue.sv | 50 +++++
 rtl/pipe_fetch_unit.sv | 86 ++++++++
 tb/tb_pipe_fetch_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared fetch-path widths, constants and the fetch-queue entry type
package pipe_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc_add_4;
  } fetch_entry_t;
endpackage

// File: rtl/pipe_fetch_unit_if.sv
// pipe_fetch_unit_if: instruction-memory request/response bus
//   req/addr : fetch request and address (master -> memory)
//   gnt      : request accepted this cycle (memory -> master)
//   rvalid/rdata : in-order response, one per granted request (memory -> master)
interface pipe_fetch_unit_if #(parameter int ADDR_W = 32);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [pipe_pkg::INSTR_W-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: parameterised synchronous FIFO, flush has priority over push/pop
//   push_i/data_i : enqueue (accepted when not full, or when popping the same cycle)
//   pop_i/data_o  : dequeue head (ignored when empty)
//   flush_i       : empty the queue
//   full_o/empty_o/count_o : occupancy status
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter type T = logic,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T data_i,
  output T data_o,
  output logic full_o,
  output logic empty_o,
  output logic [AW:0] count_o
);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == DEPTH[AW:0];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  always_comb begin
    do_pop = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk_i)
    if (do_push & ~flush_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: IF front end - PC, variable-latency imem requests, in-order fetch queue to ID
//   clk_i, rst_n         : clock, asynchronous active-low reset
//   imem (master)        : req/addr out, gnt/rvalid/rdata in
//   redirect_i/_pc_i     : taken branch, squashes all younger work
//   id_valid_o/_instr_o/_pc_add_4_o, id_ready_i : head-of-queue handshake to ID
//   PIPE_FETCH_PERF_EN   : adds perf_fetch_cnt_o / perf_flush_cnt_o
module pipe_fetch_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  pipe_fetch_unit_if.master imem,
  input  logic redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic id_valid_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0] id_pc_add_4_o,
  input  logic id_ready_i
`ifdef PIPE_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
  logic [ADDR_W-1:0] pc_q, pc_d, tag_head;
  logic [AW:0] drop_q, drop_d, occ, tag_cnt;
  logic issue, accept, dropping, pop, dq_full, dq_empty, tq_full, tq_empty;
  fetch_entry_t entry, head;
  // occupancy + in-flight (tag count; drop is zero whenever req can be high) reserves a slot per request
  assign imem.req = rst_n & ~redirect_i & ~dq_full & ~tq_full & (drop_q == '0)
                  & ({1'b0, occ} + {1'b0, tag_cnt} < DEPTH[AW+1:0]);
  assign imem.addr = pc_q;
  always_comb begin
    issue = imem.req & imem.gnt;
    dropping = imem.rvalid & (drop_q != '0);
    accept = imem.rvalid & ~dropping & ~redirect_i & ~tq_empty;
    pop = id_valid_o & id_ready_i & ~redirect_i;
    pc_d = redirect_i ? redirect_pc_i : issue ? pc_q + INC : pc_q;
    // on redirect every surviving in-flight request becomes a drop; a response this cycle is already gone
    drop_d = redirect_i ? drop_q + tag_cnt - {{AW{1'b0}}, imem.rvalid}
                        : drop_q - {{AW{1'b0}}, dropping};
    entry = '{instr: imem.rdata, pc_add_4: PC_W'(tag_head + INC)};
  end
  fetch_queue #(.DEPTH(DEPTH), .T(logic [ADDR_W-1:0])) u_tag_q (
    .clk_i, .rst_n,
    .push_i(issue), .pop_i(accept), .flush_i(redirect_i),
    .data_i(pc_q), .data_o(tag_head),
    .full_o(tq_full), .empty_o(tq_empty), .count_o(tag_cnt)
  );
  fetch_queue #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_q (
    .clk_i, .rst_n,
    .push_i(accept), .pop_i(pop), .flush_i(redirect_i),
    .data_i(entry), .data_o(head),
    .full_o(dq_full), .empty_o(dq_empty), .count_o(occ)
  );
  assign id_valid_o = ~dq_empty;
  assign id_instr_o = dq_empty ? NOP_INSTR : head.instr;
  assign id_pc_add_4_o = dq_empty ? '0 : ADDR_W'(head.pc_add_4);
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      drop_q <= drop_d;
    end
`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(pop);
      flush_cnt_q <= flush_cnt_q + (redirect_i ? 32'(occ) + 32'(imem.rvalid) : 32'(dropping));
    end
  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_fetch_unit.sv
// tb_pipe_fetch_unit: scoreboard bench for pipe_fetch_unit with an in-order variable-latency memory
module tb_pipe_fetch_unit;
  import pipe_pkg::*;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  logic clk = 0, rst_n = 0, redirect = 0, id_ready = 0, id_valid;
  logic [31:0] redirect_pc = '0, id_instr, id_pc_add_4, exp_pc = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1;
  bit gnt_rand = 0;
  logic [31:0] exp_q[$];
  pend_t pend[$];
`ifdef PIPE_FETCH_PERF_EN
  logic [31:0] pf, pl;
`endif
  pipe_fetch_unit_if #(.ADDR_W(32)) imem();
  pipe_fetch_unit dut (
    .clk_i(clk), .rst_n(rst_n), .imem(imem),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_instr_o(id_instr), .id_pc_add_4_o(id_pc_add_4), .id_ready_i(id_ready)
`ifdef PIPE_FETCH_PERF_EN
    , .perf_fetch_cnt_o(pf), .perf_flush_cnt_o(pl)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction
  // memory: decides grant and response for the coming rising edge, mid low phase
  always begin
    @(negedge clk);
    #2;
    cyc++;
    imem.gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    if (!rst_n) pend.delete();
    else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem.rvalid = 1'b1;
        imem.rdata = word(pend[0].addr);
        void'(pend.pop_front());
      end
      if (imem.req && imem.gnt) pend.push_back('{addr: imem.addr, due: cyc + lat});
    end
  end
  // scoreboard consumer: every delivery must match the next expected address
  always begin
    logic [31:0] e, e4;
    @(negedge clk);
    #3;
    if (rst_n && id_valid && id_ready && !redirect) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got pc_add_4=%h instr=%h, required no delivery", id_pc_add_4, id_instr);
      end else begin
        e = exp_q.pop_front();
        e4 = e + 32'd4;
        if (id_pc_add_4 !== e4 || id_instr !== word(e)) begin
          n_bad++;
          $display("FAIL sb_deliver: got pc_add_4=%h instr=%h, required pc_add_4=%h instr=%h", id_pc_add_4, id_instr, e4, word(e));
        end
      end
    end
  end
  task automatic do_reset(input int l);
    @(negedge clk);
    rst_n = 0; redirect = 0; id_ready = 0; gnt_rand = 0; lat = l;
    exp_q.delete();
    exp_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask
  task automatic wait_drain(input int budget, input bit rnd, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
      else id_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    id_ready = 0;
  endtask
  task automatic test_reset;
    bit ok;
    @(negedge clk);
    rst_n = 0; id_ready = 1; lat = 1;
    exp_q.delete();
    exp_pc = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (imem.req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b, required 0", imem.req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h, required 0", id_instr); end
    n_cmp++; if (id_pc_add_4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4: got %h, required 0", id_pc_add_4); end
    n_cmp++; if (imem.addr !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h, required 0", imem.addr); end
    @(negedge clk);
    rst_n = 1;
    push_exp(6);
    @(negedge clk);
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got valid %b, required 0", id_valid); end
    n_cmp++; if (imem.addr !== 32'h4) begin n_bad++; $display("FAIL lat_pc: got %h, required 00000004", imem.addr); end
    @(negedge clk);
    #1;
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid: got %b, required 1", id_valid); end
    n_cmp++; if (id_pc_add_4 !== 32'h4) begin n_bad++; $display("FAIL lat_pc4: got %h, required 00000004", id_pc_add_4); end
    wait_drain(60, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_stall;
    bit ok;
    do_reset(1);
    push_exp(4);
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b, required 1", id_valid); end
    n_cmp++; if (imem.req !== 1'b0) begin n_bad++; $display("FAIL stall_req: got %b, required 0", imem.req); end
    n_cmp++; if (id_pc_add_4 !== 32'h4) begin n_bad++; $display("FAIL stall_head: got %h, required 00000004", id_pc_add_4); end
    n_cmp++; if (id_instr !== word(32'h0)) begin n_bad++; $display("FAIL stall_instr: got %h, required %h", id_instr, word(32'h0)); end
    id_ready = 1;
    @(negedge clk);
    #1;
    n_cmp++; if (id_valid !== 1'b1 || id_pc_add_4 !== 32'h8) begin n_bad++; $display("FAIL stall_b2b: got valid %b pc4 %h, required 1 00000008", id_valid, id_pc_add_4); end
    wait_drain(40, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_redirect;
    bit ok;
`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] fl0;
`endif
    do_reset(3);
    repeat (2) @(negedge clk);
`ifdef PIPE_FETCH_PERF_EN
    fl0 = pl;
`endif
    redirect = 1; redirect_pc = 32'h100;
    exp_q.delete();
    exp_pc = 32'h100;
    #1;
    n_cmp++; if (imem.req !== 1'b0) begin n_bad++; $display("FAIL redir_req: got %b, required 0", imem.req); end
    @(negedge clk);
    redirect = 0;
    #1;
    n_cmp++; if (imem.req !== 1'b0 || id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_drop1: got req %b valid %b, required 0 0", imem.req, id_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (imem.req !== 1'b0) begin n_bad++; $display("FAIL redir_drop2: got req %b, required 0", imem.req); end
    @(negedge clk);
    #1;
    n_cmp++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin n_bad++; $display("FAIL redir_target: got req %b addr %h, required 1 00000100", imem.req, imem.addr); end
`ifdef PIPE_FETCH_PERF_EN
    n_cmp++; if (pl - fl0 !== 32'd2) begin n_bad++; $display("FAIL perf_flush: got %0d, required 2", pl - fl0); end
`endif
    push_exp(3);
    id_ready = 1;
    wait_drain(60, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL redir_drain: got %0d left, required 0", exp_q.size()); end
`ifdef PIPE_FETCH_PERF_EN
    n_cmp++; if (pf !== 32'd3) begin n_bad++; $display("FAIL perf_fetch: got %0d, required 3", pf); end
`endif
  endtask
  task automatic test_redirect_collide;
    bit ok, found;
    do_reset(1);
    push_exp(8);
    id_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = id_valid && pend.size() > 0 && pend[0].due <= cyc + 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL collide_setup: got no rvalid+handshake cycle, required one"); end
    redirect = 1; redirect_pc = 32'h40;
    exp_q.delete();
    exp_pc = 32'h40;
    #4;
    n_cmp++; if (imem.rvalid !== 1'b1 || id_valid !== 1'b1) begin n_bad++; $display("FAIL collide_cond: got rvalid %b valid %b, required 1 1", imem.rvalid, id_valid); end
    @(negedge clk);
    redirect = 0;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL collide_empty: got valid %b, required 0", id_valid); end
    push_exp(3);
    wait_drain(60, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL collide_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_double_redirect;
    bit ok;
    do_reset(3);
    id_ready = 1;
    repeat (2) @(negedge clk);
    redirect = 1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 0;
    exp_pc = 32'h300;
    #1;
    n_cmp++; if (imem.req !== 1'b0) begin n_bad++; $display("FAIL dbl_drop: got req %b, required 0", imem.req); end
    push_exp(4);
    wait_drain(80, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dbl_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_wrap;
    bit ok, seen;
    do_reset(1);
    @(negedge clk);
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete();
    exp_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 0;
    push_exp(3);
    id_ready = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = id_valid;
    end
    n_cmp++; if (!seen || id_pc_add_4 !== 32'h0) begin n_bad++; $display("FAIL wrap_first: got valid %b pc4 %h, required 1 00000000", seen, id_pc_add_4); end
    wait_drain(40, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_back_to_back;
    bit ok;
    do_reset(2);
    gnt_rand = 1;
    push_exp(24);
    id_ready = 1;
    wait_drain(600, 1, ok);
    gnt_rand = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain: got %0d left, required 0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_double_redirect();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog");
  end
endmodule
